// File: rtl/link_sup_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : link_sup_pkg
//  Description : Shared state encodings and width helpers for link_supervisor
//  Revision    : 1.0 - initial release
// ============================================================================
package link_sup_pkg;

    // FSM state encodings (also exported on o_state)
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_send   = 3'd1;
    localparam logic [2:0] c_st_wait   = 3'd2;
    localparam logic [2:0] c_st_hold   = 3'd3;
    localparam logic [2:0] c_st_linked = 3'd4;

    // Larger of two integers
    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Timer width: must hold (largest limit - 1); never narrower than 1 bit
    function automatic int timer_w(input int a, input int b, input int c, input int d);
        int m;
        m = max_of(max_of(a, b), max_of(c, d));
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/link_timer.sv
`default_nettype none
// ============================================================================
//  Module      : link_timer
//  Description : Clearable up-counter with enable; o_hit flags the terminal
//                count (i_last) while counting is enabled
//  Revision    : 1.0 - initial release
// ============================================================================
module link_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic         o_hit
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear has priority over counting; a hit always causes a state change
    // (and therefore a clear), so the counter never wraps past i_last
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_hit = i_en && (cnt_q == i_last);

endmodule
`default_nettype wire

// File: rtl/link_supervisor.sv
`default_nettype none
// ============================================================================
//  Module      : link_supervisor
//  Description : Link-management FSM driving a request/response engine with
//                link-up threshold, response timeout with retries, keepalive
//                probes, optional active probing and event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module link_supervisor
    import link_sup_pkg::*;
#(
    parameter int P_TIMEOUT_CYC   = 1000000,
    parameter int P_KEEPALIVE_CYC = 50000000,
    parameter int P_GAP_CYC       = 1000,
    parameter int P_PROBE_CYC     = 25000000,
    parameter int P_MAX_RETRY     = 3,
    parameter int P_LINK_THRESH   = 2,
    parameter int P_ACTIVE        = 1,
    parameter int P_CNT_W         = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_done,
    output logic               o_send,
    output logic               o_link,
    output logic [2:0]         o_state,
    output logic               o_timeout,
    output logic [P_CNT_W-1:0] o_tx_cnt,
    output logic [P_CNT_W-1:0] o_rx_cnt,
    output logic [P_CNT_W-1:0] o_drop_cnt
);

    localparam int TW = timer_w(P_TIMEOUT_CYC, P_KEEPALIVE_CYC, P_GAP_CYC, P_PROBE_CYC);
    localparam int GW = $clog2(P_LINK_THRESH + 1);
    localparam int RW = $clog2(P_MAX_RETRY + 1);

    localparam logic [TW-1:0] c_probe_last   = TW'(P_PROBE_CYC - 1);
    localparam logic [TW-1:0] c_timeout_last = TW'(P_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] c_gap_last     = TW'(P_GAP_CYC - 1);
    localparam logic [TW-1:0] c_keep_last    = TW'(P_KEEPALIVE_CYC - 1);
    localparam logic [GW-1:0] c_thresh       = GW'(P_LINK_THRESH);
    localparam logic [GW:0]   c_thresh_x     = (GW + 1)'(P_LINK_THRESH);
    localparam logic [RW-1:0] c_max_retry    = RW'(P_MAX_RETRY);
    localparam logic          c_active       = (P_ACTIVE != 0);

    logic [2:0]         state_q,   state_d;
    logic               send_q,    send_d;
    logic               link_q,    link_d;
    logic               timeout_q, timeout_d;
    logic [GW-1:0]      good_q,    good_d;
    logic [RW-1:0]      retry_q,   retry_d;
    logic [P_CNT_W-1:0] tx_q,      tx_d;
    logic [P_CNT_W-1:0] rx_q,      rx_d;
    logic [P_CNT_W-1:0] drop_q,    drop_d;

    logic          w_drop_evt;
    logic          w_hit;
    logic          w_tmr_en;
    logic          w_tmr_clr;
    logic [TW-1:0] w_last;

    // Select the terminal count and counting enable for the current state
    always_comb begin
        w_last   = '0;
        w_tmr_en = 1'b0;
        case (state_q)
            c_st_idle:   begin w_last = c_probe_last;   w_tmr_en = c_active; end
            c_st_wait:   begin w_last = c_timeout_last; w_tmr_en = 1'b1;     end
            c_st_hold:   begin w_last = c_gap_last;     w_tmr_en = 1'b1;     end
            c_st_linked: begin w_last = c_keep_last;    w_tmr_en = 1'b1;     end
            default:     begin w_last = '0;             w_tmr_en = 1'b0;     end
        endcase
        w_tmr_en = w_tmr_en && i_en;
    end

    // Any state change (including a forced return to IDLE) restarts the timer
    assign w_tmr_clr = !i_en || (state_d != state_q);

    link_timer #(
        .W (TW)
    ) u_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .i_last  (w_last),
        .o_hit   (w_hit)
    );

    // Next-state and link bookkeeping
    always_comb begin
        state_d    = state_q;
        link_d     = link_q;
        good_d     = good_q;
        retry_d    = retry_q;
        timeout_d  = 1'b0;
        w_drop_evt = 1'b0;
        if (!i_en) begin
            state_d    = c_st_idle;
            link_d     = 1'b0;
            good_d     = '0;
            retry_d    = '0;
            w_drop_evt = link_q;
        end else begin
            case (state_q)
                c_st_idle: begin
                    link_d  = 1'b0;
                    good_d  = '0;
                    retry_d = '0;
                    if (i_done || (c_active && w_hit)) begin
                        state_d = c_st_send;
                    end
                end
                c_st_send: begin
                    state_d = c_st_wait;
                end
                c_st_wait: begin
                    // A response arriving on the timeout cycle still counts
                    if (i_done) begin
                        retry_d = '0;
                        if (good_q < c_thresh) begin
                            good_d = good_q + 1'b1;
                        end
                        if (link_q || (({1'b0, good_q} + 1'b1) >= c_thresh_x)) begin
                            state_d = c_st_linked;
                            link_d  = 1'b1;
                        end else begin
                            state_d = c_st_hold;
                        end
                    end else if (w_hit) begin
                        timeout_d = 1'b1;
                        good_d    = '0;
                        if ((retry_q + 1'b1) == c_max_retry) begin
                            state_d    = c_st_idle;
                            link_d     = 1'b0;
                            retry_d    = '0;
                            w_drop_evt = link_q;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            state_d = c_st_send;
                        end
                    end
                end
                c_st_hold: begin
                    if (w_hit) begin
                        state_d = c_st_send;
                    end
                end
                c_st_linked: begin
                    link_d = 1'b1;
                    // Reply and keepalive collapse into a single exchange
                    if (i_done || w_hit) begin
                        state_d = c_st_send;
                    end
                end
                default: begin
                    state_d = c_st_idle;
                    link_d  = 1'b0;
                end
            endcase
        end
    end

    // Event counters: tx/rx wrap, drop saturates
    always_comb begin
        send_d = (state_d == c_st_send);
        tx_d   = send_d ? (tx_q + 1'b1) : tx_q;
        rx_d   = (i_en && i_done) ? (rx_q + 1'b1) : rx_q;
        drop_d = (w_drop_evt && (drop_q != {P_CNT_W{1'b1}})) ? (drop_q + 1'b1) : drop_q;
    end

    // State and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= c_st_idle;
            send_q    <= 1'b0;
            link_q    <= 1'b0;
            timeout_q <= 1'b0;
            good_q    <= '0;
            retry_q   <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            send_q    <= send_d;
            link_q    <= link_d;
            timeout_q <= timeout_d;
            good_q    <= good_d;
            retry_q   <= retry_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            drop_q    <= drop_d;
        end
    end

    assign o_send     = send_q;
    assign o_link     = link_q;
    assign o_state    = state_q;
    assign o_timeout  = timeout_q;
    assign o_tx_cnt   = tx_q;
    assign o_rx_cnt   = rx_q;
    assign o_drop_cnt = drop_q;

endmodule
`default_nettype wire

// File: doc/link_supervisor.md
Name: link_supervisor

Overview:
Parametrised link-management FSM that drives a request/response protocol engine through a one-cycle send strobe and a one-cycle done pulse. Adds four things over a fixed three-state link FSM: a configurable link-up threshold, a response timeout with bounded retries, a keepalive probe, and an optional active-probe mode. It also exports status and event counters. It sits between the top-level task control and the MHP engine; the engine's Ethernet ports do not pass through this block.

Parameters:
P_TIMEOUT_CYC, 1000000, max cycles WAIT waits for i_done (>=2)
P_KEEPALIVE_CYC, 50000000, idle cycles in LINKED before a probe is sent (>=2)
P_GAP_CYC, 1000, cycles HOLD waits between exchanges during link-up (>=1)
P_PROBE_CYC, 25000000, IDLE probe interval when P_ACTIVE=1 (>=2)
P_MAX_RETRY, 3, consecutive timeouts tolerated before link-down (>=1)
P_LINK_THRESH, 2, consecutive successful exchanges needed to assert link (>=1)
P_ACTIVE, 1, 1 = IDLE self-initiates probes; 0 = IDLE waits only for peer i_done
P_CNT_W, 16, width of event counters

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  supervisor enable; low forces IDLE
i_done  in  1  one-cycle pulse from protocol engine: exchange/frame completed
o_send  out  1  one-cycle strobe to protocol engine: start exchange
o_link  out  1  link established
o_state  out  3  current state encoding (debug)
o_timeout  out  1  one-cycle pulse on each WAIT timeout
o_tx_cnt  out  P_CNT_W  o_send strobes issued, wraps modulo 2^P_CNT_W
o_rx_cnt  out  P_CNT_W  i_done pulses seen in any state while i_en=1, wraps
o_drop_cnt  out  P_CNT_W  link-down events, saturates at all-ones

Behaviour:
- Reset (async, i_rst_n=0): state=IDLE. All outputs 0. Timer, good_cnt and retry_cnt = 0. Release takes effect on the first i_clk edge with i_rst_n=1.
- All outputs are registered. o_send is high exactly during the single cycle the FSM is in SEND.
- States: IDLE=0, SEND=1, WAIT=2, HOLD=3, LINKED=4.
- i_en=0 in any state: next state IDLE. o_link, good_cnt, retry_cnt and timer are cleared. No o_send. If o_link was 1, o_drop_cnt increments.
- IDLE: o_link=0, good_cnt=0, retry_cnt=0.
  - i_done -> SEND.
  - Else, if P_ACTIVE=1, the timer counts; when timer==P_PROBE_CYC-1 -> SEND.
- SEND: o_send=1, o_tx_cnt++, timer cleared -> WAIT. Any i_done in this cycle is counted in o_rx_cnt but is not taken as the response.
- WAIT: timer increments each cycle.
  - i_done: retry_cnt=0, good_cnt++ (saturating). If o_link=1 or good_cnt+1>=P_LINK_THRESH -> LINKED with o_link=1 from the next cycle. Else -> HOLD.
  - timer==P_TIMEOUT_CYC-1 with no i_done: o_timeout pulse, retry_cnt++, good_cnt=0.
    - If retry_cnt+1==P_MAX_RETRY -> IDLE, o_link cleared; if it was 1, o_drop_cnt++.
    - Else -> SEND.
  - i_done and timeout in the same cycle: i_done wins; no timeout is recorded.
- HOLD: timer counts; at timer==P_GAP_CYC-1 -> SEND. i_done in HOLD is counted only.
- LINKED: o_link=1, timer counts from entry or from the last i_done.
  - i_done -> SEND (reply).
  - timer==P_KEEPALIVE_CYC-1 -> SEND (keepalive probe).
  - Both conditions in the same cycle produce one SEND.
- o_link stays 1 through SEND/WAIT retries after LINKED. It clears only on retry exhaustion or i_en=0.
- Timer width = clog2(max of the four cycle parameters). Every state transition clears the timer.
- Counter arithmetic: tx/rx wrap; drop saturates; good_cnt saturates at P_LINK_THRESH.

Decomposition:
- Package link_sup_pkg holds: state localparams, a clog2-based TIMER_W derivation function, and a max() helper.
- One natural sub-module: link_timer. It is a clearable up-counter with enable and a comparator producing a terminal pulse, instantiated once and loaded with the limit for the current state.

Test Plan:
All scenarios use TIMEOUT=8, KEEPALIVE=20, GAP=2, PROBE=10, MAX_RETRY=2, THRESH=2, ACTIVE=1, CNT_W=8.
1. Reset mid-WAIT (i_rst_n low 3 cycles) -> all outputs 0 immediately, state IDLE; first probe o_send 11 cycles after release.
2. Link-up: respond i_done 3 cycles after each o_send -> second response takes the FSM to LINKED, o_link=1 one cycle later; o_tx_cnt=2, o_rx_cnt=2.
3. Keepalive: stay silent in LINKED -> o_send exactly 20 cycles after LINKED entry; a reply within 8 cycles keeps o_link=1 with no timeout.
4. Link loss: stop responding while LINKED -> two o_timeout pulses 9 cycles apart (SEND+8); o_link drops after the second; o_drop_cnt=1; state IDLE.
5. i_done and timeout in the same cycle in WAIT -> no o_timeout, retry_cnt=0, FSM proceeds as success.
6. P_ACTIVE=0: no i_done for 100 cycles -> no o_send. Peer i_done -> o_send next cycle. i_en dropped while linked -> o_link=0 next cycle, o_drop_cnt++.
